// File: rtl/trivium_stream.sv
// Trivium keystream generator: 80-bit key/IV load, INIT_ROUNDS warm-up steps,
// then W keystream bits per cycle behind a valid/ready handshake.
module trivium_stream #(
    parameter int unsigned W           = 8,
    parameter int unsigned INIT_ROUNDS = 1152
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [79:0]  key,
    input  logic [79:0]  iv,
    output logic         busy,
    output logic [W-1:0] ks_data,
    output logic         ks_valid,
    input  logic         ks_ready
);

    localparam int unsigned INIT_CYCLES = INIT_ROUNDS / W;
    localparam int unsigned CW          = $clog2(INIT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN
    } state_t;

    state_t         state;
    state_t         state_nx;

    // s[i-1] holds Trivium state bit s_i
    logic [287:0]   s;
    logic [287:0]   s_adv;
    logic [287:0]   s_load;
    logic [W-1:0]   z_word;
    logic [CW-1:0]  cnt;
    logic           last_init;
    logic           advance_run;
    logic           t1, t2, t3;
    logic           t1f, t2f, t3f;

    assign busy        = (state == INIT);
    assign last_init   = (cnt == CW'(INIT_CYCLES - 1));
    assign advance_run = (state == RUN) && (!ks_valid || ks_ready);

    // W chained cipher steps; z of step j lands in word bit j
    always_comb begin
        s_adv  = s;
        z_word = '0;
        t1     = 1'b0;
        t2     = 1'b0;
        t3     = 1'b0;
        t1f    = 1'b0;
        t2f    = 1'b0;
        t3f    = 1'b0;
        for (int unsigned j = 0; j < W; j++) begin
            t1        = s_adv[65]  ^ s_adv[92];
            t2        = s_adv[161] ^ s_adv[176];
            t3        = s_adv[242] ^ s_adv[287];
            z_word[j] = t1 ^ t2 ^ t3;
            t1f       = t1 ^ (s_adv[90]  & s_adv[91])  ^ s_adv[170];
            t2f       = t2 ^ (s_adv[174] & s_adv[175]) ^ s_adv[263];
            t3f       = t3 ^ (s_adv[285] & s_adv[286]) ^ s_adv[68];
            s_adv     = {s_adv[286:177], t2f, s_adv[175:93], t1f, s_adv[91:0], t3f};
        end
    end

    // Initial state image built from key and iv (key[79] -> s1, iv[79] -> s94)
    always_comb begin
        s_load = '0;
        for (int unsigned i = 0; i < 80; i++) begin
            s_load[i]      = key[79 - i];
            s_load[93 + i] = iv[79 - i];
        end
        s_load[287:285] = '1;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; load overrides every state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = IDLE;
            INIT:    if (last_init) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = IDLE;
        endcase
        if (load) begin
            state_nx = INIT;
        end
    end

    // Cipher state, warm-up counter and output word register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s        <= '0;
            cnt      <= '0;
            ks_data  <= '0;
            ks_valid <= 1'b0;
        end else if (load) begin
            s        <= s_load;
            cnt      <= '0;
            ks_valid <= 1'b0;
        end else if (state == INIT) begin
            s   <= s_adv;
            cnt <= cnt + CW'(1);
        end else if (advance_run) begin
            s        <= s_adv;
            ks_data  <= z_word;
            ks_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_trivium_stream.sv
// Bench for trivium_stream: W=1, W=8 and W=64 instances share key/iv/load/rst
// and are checked every cycle against a bit-serial Trivium reference.
module tb_trivium_stream;

    localparam int NBITS = 4096;
    localparam logic [79:0] KEY_A = 80'h9719CFC92A9FF688F9AA;
    localparam logic [79:0] IV_A  = 80'hECBB76B09AFF71D0D151;
    localparam logic [79:0] KEY_B = 80'h0123456789ABCDEF0123;
    localparam logic [79:0] IV_B  = 80'hFEDCBA9876543210FEDC;

    typedef enum int {M_IDLE, M_INIT, M_RUN} mmode_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [79:0] key;
    logic [79:0] iv;
    logic [2:0]  ready;
    logic [2:0]  dut_busy;
    logic [2:0]  dut_valid;
    logic [0:0]  d1;
    logic [7:0]  d8;
    logic [63:0] d64;
    int          key_sel;

    int checks   = 0;
    int failures = 0;

    // reference keystreams: 0 = key A, 1 = key B, 2..4 = no-warm-up pin cases
    bit gold [5][NBITS];

    mmode_t      mode  [3];
    int          cnt_m [3];
    bit          mvld  [3];
    bit          mknown[3];
    logic [63:0] mword [3];
    int          ptr   [3];
    int          mset  [3];
    bit          pins_done = 1'b0;

    always #5 clk = ~clk;

    trivium_stream #(.W(1), .INIT_ROUNDS(1152)) u_w1 (
        .clk(clk), .rst(rst), .load(load), .key(key), .iv(iv),
        .busy(dut_busy[0]), .ks_data(d1), .ks_valid(dut_valid[0]), .ks_ready(ready[0])
    );
    trivium_stream #(.W(8), .INIT_ROUNDS(1152)) u_w8 (
        .clk(clk), .rst(rst), .load(load), .key(key), .iv(iv),
        .busy(dut_busy[1]), .ks_data(d8), .ks_valid(dut_valid[1]), .ks_ready(ready[1])
    );
    trivium_stream #(.W(64), .INIT_ROUNDS(1152)) u_w64 (
        .clk(clk), .rst(rst), .load(load), .key(key), .iv(iv),
        .busy(dut_busy[2]), .ks_data(d64), .ks_valid(dut_valid[2]), .ks_ready(ready[2])
    );

    function automatic int lane_w(input int i);
        case (i)
            0:       return 1;
            1:       return 8;
            default: return 64;
        endcase
    endfunction

    function automatic logic [63:0] lane_data(input int i);
        case (i)
            0:       return {63'b0, d1};
            1:       return {56'b0, d8};
            default: return d64;
        endcase
    endfunction

    // Trivium as published: three shift registers A(93), B(84), C(111)
    task automatic gen_gold(input int set, input logic [79:0] k, input logic [79:0] v,
                            input int warm);
        logic [1:93]  a;
        logic [1:84]  b;
        logic [1:111] c;
        logic         t1, t2, t3;
        a = '0;
        b = '0;
        c = '0;
        for (int i = 1; i <= 80; i++) begin
            a[i] = k[80 - i];
            b[i] = v[80 - i];
        end
        c[109] = 1'b1;
        c[110] = 1'b1;
        c[111] = 1'b1;
        for (int n = 0; n < warm + NBITS; n++) begin
            t1 = a[66] ^ a[93];
            t2 = b[69] ^ b[84];
            t3 = c[66] ^ c[111];
            if (n >= warm) gold[set][n - warm] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (a[91] & a[92]) ^ b[78];
            t2 = t2 ^ (b[82] & b[83]) ^ c[87];
            t3 = t3 ^ (c[109] & c[110]) ^ a[69];
            a  = {t3, a[1:92]};
            b  = {t1, b[1:83]};
            c  = {t2, c[1:110]};
        end
    endtask

    task automatic chk(input string nm, input int lane, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s lane%0d t=%0t: got %h expected %h", nm, lane, $time, act, exp);
        end
    endtask

    // single compare process: pins the reference, then checks every lane every cycle
    always @(negedge clk) begin
        logic [63:0] pin;
        int          lw;
        if (!pins_done) begin
            pin = '0;
            for (int j = 0; j < 8; j++) pin[j] = gold[2][j];
            chk("pin_zero_first8", 0, pin, 64'h07);
            chk("pin_zero_z65", 0, {63'b0, gold[2][65]}, 64'd0);
            chk("pin_k1_z65",   0, {63'b0, gold[3][65]}, 64'd1);
            chk("pin_zero_z68", 0, {63'b0, gold[2][68]}, 64'd1);
            chk("pin_iv1_z68",  0, {63'b0, gold[4][68]}, 64'd0);
            pins_done = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            lw = lane_w(i);
            if (!rst) begin
                chk("rst_busy",  i, {63'b0, dut_busy[i]},  64'd0);
                chk("rst_valid", i, {63'b0, dut_valid[i]}, 64'd0);
                chk("rst_data",  i, lane_data(i),          64'd0);
                mode[i] = M_IDLE;
                mvld[i] = 1'b0;
            end else begin
                chk("busy",  i, {63'b0, dut_busy[i]},  {63'b0, mode[i] == M_INIT});
                chk("valid", i, {63'b0, dut_valid[i]}, {63'b0, mvld[i]});
                if (mvld[i] && mknown[i]) chk("data", i, lane_data(i), mword[i]);
                if (load) begin
                    mode[i]  = M_INIT;
                    cnt_m[i] = 1152 / lw;
                    mvld[i]  = 1'b0;
                    ptr[i]   = 0;
                    mset[i]  = key_sel;
                end else if (mode[i] == M_INIT) begin
                    cnt_m[i]--;
                    if (cnt_m[i] == 0) mode[i] = M_RUN;
                end else if (mode[i] == M_RUN && (!mvld[i] || ready[i])) begin
                    mvld[i]   = 1'b1;
                    mknown[i] = (ptr[i] + lw <= NBITS);
                    mword[i]  = '0;
                    if (mknown[i])
                        for (int j = 0; j < lw; j++) mword[i][j] = gold[mset[i]][ptr[i] + j];
                    ptr[i] += lw;
                end
            end
        end
    end

    task automatic pulse_load(input logic [79:0] k, input logic [79:0] v, input int sel);
        key     = k;
        iv      = v;
        key_sel = sel;
        load    = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        load    = 1'b0;
        key     = '0;
        iv      = '0;
        key_sel = 0;
        ready   = 3'b111;
        gen_gold(0, KEY_A, IV_A, 1152);
        gen_gold(1, KEY_B, IV_B, 1152);
        gen_gold(2, 80'h0, 80'h0, 0);
        gen_gold(3, {1'b1, 79'h0}, 80'h0, 0);
        gen_gold(4, 80'h0, {1'b1, 79'h0}, 0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // key A: full stream on all widths, W=8 stalled for 10 cycles mid-RUN
        pulse_load(KEY_A, IV_A, 0);
        repeat (144 + 200) @(posedge clk);
        #1 ready[1] = 1'b0;
        repeat (10) @(posedge clk);
        #1 ready[1] = 1'b1;
        repeat (4950) @(posedge clk);
        #1;

        // reload mid-RUN with key B
        pulse_load(KEY_B, IV_B, 1);
        repeat (1152 + 300) @(posedge clk);
        #1;

        // asynchronous reset in INIT cycle 50, then idle without load
        pulse_load(KEY_A, IV_A, 0);
        repeat (50) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // load coinciding with the final W=8 INIT cycle
        pulse_load(KEY_A, IV_A, 0);
        repeat (143) @(posedge clk);
        #1;
        pulse_load(KEY_B, IV_B, 1);
        repeat (144 + 20) @(posedge clk);
        #1;

        // load while a word is being handed over
        pulse_load(KEY_A, IV_A, 0);
        repeat (200) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
